// File: rtl/input_cond_pkg.sv
// Shared defaults and helpers for the input conditioner.
// Board-level widths let the board top build one instance for buttons
// and one for switches from the same defaults.
package input_cond_pkg;

  localparam int INCOND_TICK_DIV_DEF = 1000;
  localparam int INCOND_STABLE_DEF   = 20;
  localparam int INCOND_BTN_W        = 4;
  localparam int INCOND_SW_W         = 8;

  // Counter width for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_cond_if.sv
// Bus between the input conditioner and its consumer (the CPU port logic).
// Optional falling-edge path is present when INPUT_COND_FALL_EVT_EN is defined.
interface input_cond_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] evt;
  logic             irq;
`ifdef INPUT_COND_FALL_EVT_EN
  logic [WIDTH-1:0] fevt_clr;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] fevt;

  modport master (
    output raw, evt_clr, fevt_clr,
    input  state, rise, evt, fall, fevt, irq
  );

  modport slave (
    input  raw, evt_clr, fevt_clr,
    output state, rise, evt, fall, fevt, irq
  );
`else
  modport master (
    output raw, evt_clr,
    input  state, rise, evt, irq
  );

  modport slave (
    input  raw, evt_clr,
    output state, rise, evt, irq
  );
`endif

endinterface

// File: rtl/input_cond_bit.sv
// Single-bit conditioner: 2-FF synchronizer, tick-based debounce, edge pulse
// and sticky write-1-to-clear event flag. Optional falling-edge path is
// built when INPUT_COND_FALL_EVT_EN is defined.
module input_cond_bit
  import input_cond_pkg::*;
#(
  parameter int STABLE_TICKS = INCOND_STABLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic evt_clr,
  input  logic tick,
  output logic state,
  output logic rise,
  output logic evt,
  output logic evt_next
`ifdef INPUT_COND_FALL_EVT_EN
  ,
  input  logic fevt_clr,
  output logic fall,
  output logic fevt,
  output logic fevt_next
`endif
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          rise_q, rise_d;
  logic          evt_q, evt_d;
`ifdef INPUT_COND_FALL_EVT_EN
  logic          fall_q, fall_d;
  logic          fevt_q, fevt_d;
`endif

  // Next-state: synchronizer shift, debounce count on ticks, edge/event flags.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
`ifdef INPUT_COND_FALL_EVT_EN
    fall_d  = 1'b0;
`endif
    if (tick) begin
      if (s2_q == state_q) begin
        // Bounce back to the debounced level restarts the count.
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
`ifdef INPUT_COND_FALL_EVT_EN
        fall_d  = ~s2_q;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Set beats clear when both land on the same edge.
    evt_d  = rise_d | (evt_q & ~evt_clr);
`ifdef INPUT_COND_FALL_EVT_EN
    fevt_d = fall_d | (fevt_q & ~fevt_clr);
`endif
  end

  // State registers with asynchronous active-low reset.
  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which keeps the two synchronizer stages from collapsing into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      evt_q   <= 1'b0;
`ifdef INPUT_COND_FALL_EVT_EN
      fall_q  <= 1'b0;
      fevt_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      evt_q   <= evt_d;
`ifdef INPUT_COND_FALL_EVT_EN
      fall_q  <= fall_d;
      fevt_q  <= fevt_d;
`endif
    end
  end

  assign state    = state_q;
  assign rise     = rise_q;
  assign evt      = evt_q;
  assign evt_next = evt_d;
`ifdef INPUT_COND_FALL_EVT_EN
  assign fall      = fall_q;
  assign fevt      = fevt_q;
  assign fevt_next = fevt_d;
`endif

endmodule

// File: rtl/input_cond.sv
// Input conditioner for the board buttons/switches feeding PORTI/PORTJ.
// One shared sample-tick generator drives WIDTH per-bit conditioners; the
// interrupt request is the registered OR of the next event flags so it
// moves together with evt. Define INPUT_COND_FALL_EVT_EN for fall/fevt.
module input_cond
  import input_cond_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = INCOND_TICK_DIV_DEF,
  parameter int STABLE_TICKS = INCOND_STABLE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input_cond_if.slave  bus
);

  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             tick;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] state_w, rise_w, evt_w, evt_next_w;
`ifdef INPUT_COND_FALL_EVT_EN
  logic [WIDTH-1:0] fall_w, fevt_w, fevt_next_w;
`endif

  // Sample tick: one cycle out of every TICK_DIV, and irq from next flags.
  always_comb begin
    tick   = (tcnt_q == TICK_LAST);
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    irq_d  = |evt_next_w;
`ifdef INPUT_COND_FALL_EVT_EN
    irq_d  = irq_d | (|fevt_next_w);
`endif
  end

  // Tick counter and interrupt register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      irq_q  <= irq_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_cond_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (bus.raw[i]),
      .evt_clr  (bus.evt_clr[i]),
      .tick     (tick),
      .state    (state_w[i]),
      .rise     (rise_w[i]),
      .evt      (evt_w[i]),
      .evt_next (evt_next_w[i])
`ifdef INPUT_COND_FALL_EVT_EN
      ,
      .fevt_clr (bus.fevt_clr[i]),
      .fall     (fall_w[i]),
      .fevt     (fevt_w[i]),
      .fevt_next(fevt_next_w[i])
`endif
    );
  end

  assign bus.state = state_w;
  assign bus.rise  = rise_w;
  assign bus.evt   = evt_w;
  assign bus.irq   = irq_q;
`ifdef INPUT_COND_FALL_EVT_EN
  assign bus.fall  = fall_w;
  assign bus.fevt  = fevt_w;
`endif

endmodule

// File: tb/tb_input_cond.sv
// Self-checking bench for input_cond (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
// Directed scenarios followed by random input bursts; every edge is compared
// against a sample-history reference model kept in the bench.
module tb_input_cond;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] raw_v, clr_v, fclr_v;

  input_cond_if #(.WIDTH(W)) bus ();

  assign bus.raw     = raw_v;
  assign bus.evt_clr = clr_v;
`ifdef INPUT_COND_FALL_EVT_EN
  assign bus.fevt_clr = fclr_v;
`endif

  input_cond #(
    .WIDTH       (W),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: debounced level flips once the last ST tick samples
  // taken since the previous flip all disagree with it.
  logic [W-1:0] m_state, m_rise, m_evt, m_fall, m_fevt;
  logic         m_irq;
  int           cyc;
  logic [W-1:0] rawh[$];
  logic [W-1:0] tq[$];
  int           since_flip[W];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = '0; m_rise = '0; m_evt = '0; m_fall = '0; m_fevt = '0; m_irq = 1'b0;
    cyc = 0;
    rawh.delete();
    tq.delete();
    for (int i = 0; i < W; i++) since_flip[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s2, rose, fell;
    bit           tick, all_diff;
    // Synchronized value seen at this edge is raw as of two edges earlier.
    s2 = (rawh.size() == 2) ? rawh[0] : '0;
    rawh.push_back(raw_v);
    if (rawh.size() > 2) void'(rawh.pop_front());
    tick = ((cyc % TD) == TD - 1);
    rose = '0;
    fell = '0;
    if (tick) begin
      tq.push_back(s2);
      if (tq.size() > ST) void'(tq.pop_front());
      for (int i = 0; i < W; i++) begin
        since_flip[i]++;
        if (since_flip[i] >= ST) begin
          all_diff = 1'b1;
          for (int j = 0; j < ST; j++)
            if (tq[tq.size() - 1 - j][i] == m_state[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_state[i]    = ~m_state[i];
            since_flip[i] = 0;
            if (m_state[i]) rose[i] = 1'b1;
            else            fell[i] = 1'b1;
          end
        end
      end
    end
    m_rise = rose;
    m_fall = fell;
    m_evt  = rose | (m_evt & ~clr_v);
    m_fevt = fell | (m_fevt & ~fclr_v);
    m_irq  = |m_evt;
`ifdef INPUT_COND_FALL_EVT_EN
    m_irq  = m_irq | (|m_fevt);
`endif
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", bus.state, m_state);
    check("rise", bus.rise, m_rise);
    check("evt", bus.evt, m_evt);
    check("irq", W'(bus.irq), W'(m_irq));
`ifdef INPUT_COND_FALL_EVT_EN
    check("fall", bus.fall, m_fall);
    check("fevt", bus.fevt, m_fevt);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, bus.state, '0);
    check({tag, "_rise"}, bus.rise, '0);
    check({tag, "_evt"}, bus.evt, '0);
    check({tag, "_irq"}, W'(bus.irq), '0);
  endtask

  initial begin
    int  rise_cnt, n, hold;
    bit  got;

    reset  = 1'b0;
    raw_v  = 4'hF;
    clr_v  = '0;
    fclr_v = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    #9 reset = 1'b1;

    // Inputs held high through reset: all bits debounce high together.
    rise_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.rise == 4'hF) rise_cnt++;
    end
    check("p1_state", bus.state, 4'hF);
    check("p1_rise_pulses", W'(rise_cnt), 4'd1);
    check("p1_evt", bus.evt, 4'hF);
    check("p1_irq", W'(bus.irq), 4'd1);

    clr_v = 4'hF;
    step();
    clr_v = '0;
    raw_v = '0;
    repeat (16) step();

    // Bit 0 bounces every 5 clk: never stable for three ticks.
    for (int c = 0; c < 60; c++) begin
      raw_v[0] = ((c / 5) % 2 == 0);
      step();
    end
    raw_v[0] = 1'b0;
    repeat (16) step();
    check("bounce_state0", W'(bus.state[0]), '0);
    check("bounce_evt0", W'(bus.evt[0]), '0);

    // Clean 0->1 on bit 1: latency window then sticky event.
    raw_v[1] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (bus.state[1]) got = 1'b1;
    end
    check("lat1_in_window", W'(got && n >= 10 && n <= 14), 4'd1);
    raw_v[1] = 1'b0;
    repeat (16) step();
    check("fall1_state", W'(bus.state[1]), '0);
    check("fall1_evt_held", bus.evt, 4'b0010);

    // Write-1-to-clear, then clear on the same edge as a rise.
    clr_v = 4'b0010;
    step();
    clr_v = '0;
    check("clr_evt", bus.evt, '0);
    check("clr_irq", W'(bus.irq), '0);
    raw_v[1] = 1'b1;
    clr_v    = 4'b0010;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (m_rise[1]) got = 1'b1;
    end
    check("setwins_found", W'(got), 4'd1);
    check("setwins_evt1", W'(bus.evt[1]), 4'd1);
    clr_v = 4'hF;
    step();
    clr_v = '0;

    // Reset in the middle of bit 2's debounce discards the partial count.
    raw_v[2] = 1'b1;
    repeat (8) step();
    check("mid_state2", W'(bus.state[2]), '0);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    #3 reset = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (bus.state[2]) got = 1'b1;
    end
    check("restart_lat2", W'(n), 4'd12);

    // Falling edge of bit 3 after a stable high.
    raw_v[3] = 1'b1;
    repeat (16) step();
    raw_v[3] = 1'b0;
    repeat (16) step();
    check("fall3_state", W'(bus.state[3]), '0);
`ifdef INPUT_COND_FALL_EVT_EN
    check("fevt3_set", W'(bus.fevt[3]), 4'd1);
    check("fevt3_irq", W'(bus.irq), 4'd1);
`endif
    fclr_v = 4'b1000;
    step();
    fclr_v = '0;
`ifdef INPUT_COND_FALL_EVT_EN
    check("fevt3_clr", W'(bus.fevt[3]), '0);
`endif

    // Random input bursts with sparse random clears.
    for (int b = 0; b < 100; b++) begin
      raw_v = W'($urandom);
      hold  = int'($urandom_range(1, 20));
      for (int h = 0; h < hold; h++) begin
        clr_v  = W'($urandom & $urandom & $urandom);
        fclr_v = W'($urandom & $urandom & $urandom);
        step();
      end
    end
    clr_v  = '0;
    fclr_v = '0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_cond.md
Name: input_cond

Overview:
- Conditions raw board inputs (buttons, switches) into clean registered values for the computer's input ports (PORTI/PORTJ).
- Per bit:
  - 2-FF synchronizer
  - tick-based debounce counter
  - one-cycle rising-edge pulse
  - sticky event flag with write-1-to-clear
  - OR-reduced interrupt request
- Replaces free-running 100 Hz sampling of BTN/SW in the board top.
- The input-side counterpart of the 7-segment display driver.

Parameters:
- WIDTH, 8, number of input bits conditioned.
- TICK_DIV, 1000, clk cycles per sample tick (1 MHz clk gives 1 kHz sampling); legal range >=1.
- STABLE_TICKS, 20, consecutive ticks a synchronized bit must differ from its debounced state before the state flips; legal range >=1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- raw  in  WIDTH  asynchronous board inputs.
- evt_clr  in  WIDTH  write-1-to-clear for evt; sampled each clk.
- state  out  WIDTH  debounced level.
- rise  out  WIDTH  one-clk pulse on debounced 0->1.
- evt  out  WIDTH  sticky rising-edge flags.
- irq  out  1  |evt, registered.

Behaviour:
- Reset (reset==0, asynchronous):
  - sync stages, state, rise, evt, irq, tick counter and all per-bit counters go to 0.
  - Deassertion is not synchronized internally; the top provides a clean release.
- Synchronizer: s1<=raw, s2<=s1 every clk. Latency raw->s2 is 2 clk.
- Tick generator:
  - tcnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 combinationally when tcnt==TICK_DIV-1.
  - TICK_DIV==1 gives tick every cycle.
  - Width is $clog2(TICK_DIV) with a minimum of 1.
- Per bit i, on a clk edge with tick=1:
  - If s2[i]==state[i]: cnt[i]<=0.
  - Else if cnt[i]==STABLE_TICKS-1: state[i]<=s2[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Any bounce back to state[i] restarts the count.
  - Counters never wrap; max value is STABLE_TICKS-1.
- No tick: cnt and state hold.
- Latency from a clean raw transition to state change:
  - 2 clk sync, then STABLE_TICKS tick edges.
  - Worst case 2 + STABLE_TICKS*TICK_DIV clk.
- rise[i]:
  - Registered; 1 for exactly the clk cycle in which state[i] first reads as the new value 1.
  - 0 otherwise.
  - No pulse on 1->0.
- evt[i], next value:
  - 1 if rise-set condition on this edge.
  - else 0 if evt_clr[i].
  - else hold.
  - Simultaneous set and clear: set wins; the flag stays 1.
- irq: registered |evt_next, so it is coincident with evt.
- After reset with raw[i] held 1, state[i] rises after the normal debounce latency and produces rise/evt. This is intended.
- Reset mid-count discards the partial count; no pulse is emitted.

Optional Feature:
- Macro: INPUT_COND_FALL_EVT_EN.
- When defined:
  - Adds outputs fall (WIDTH, one-clk pulse on debounced 1->0) and fevt (WIDTH, sticky).
  - Adds input fevt_clr (WIDTH).
  - Same set-wins rule as evt.
  - irq = |evt | |fevt.
- When undefined:
  - Those ports are absent; irq = |evt only.
  - Area limited to rising path.

Decomposition:
- defs.v carries:
  - INCOND_TICK_DIV_DEF and INCOND_STABLE_DEF defaults.
  - Board widths INCOND_BTN_W=4 and INCOND_SW_W=8, used by the top to instantiate two copies.
- One sub-module, input_cond_bit:
  - Contains the synchronizer, counter, state, rise, evt and optional fall/fevt for a single bit.
  - Takes tick as input.
  - Instantiated WIDTH times via generate.
- Tick generator stays in input_cond and is shared by all bits.

Test Plan (bench: WIDTH=4, TICK_DIV=4, STABLE_TICKS=3):
- Reset with raw=4'hF, then release; hold raw -> state=4'hF after at most 2+12 clk. rise=4'hF for exactly 1 clk. evt=4'hF, irq=1.
- raw[0] toggles 0/1 every 5 clk for 60 clk -> state[0] stays 0, rise never asserts, evt[0]=0.
- raw[1] goes 0->1 cleanly -> state[1] changes within [2+8, 2+12] clk. One rise pulse; evt[1]=1 persists; later 1->0 gives no rise and evt holds.
- With evt=4'b0010, assert evt_clr=4'b0010 for 1 clk -> evt=0 and irq=0 next cycle. Repeat with evt_clr on the same clk as a rise[1] pulse -> evt[1] remains 1.
- Assert reset mid-debounce of raw[2] after 2 ticks -> all outputs 0 immediately (asynchronous). After release, full STABLE_TICKS count restarts.
- With INPUT_COND_FALL_EVT_EN: raw[3] 1->0 after stable high -> one fall[3] pulse, fevt[3]=1, irq=1. fevt_clr clears it; rise and evt unaffected.
